sha256_sigma_unit: RTL and testbench

- Registered SHA-256 logical-function unit covering Function1, Function2 and Function3 of the hash datapath.
  - Function1 = Σ0 (big sigma 0)
  - Function2 = Σ1 (big sigma 1)
  - Function3 = σ0 (small sigma 0, message schedule)
- One 32-bit word in; all three results out together after one clock.
- Feeds the compression round adders and the message-schedule expander.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_sigma_core.sv | 36 +++
 rtl/sha256_sigma_unit.sv | 65 ++++++
 tb/tb_sha256_sigma_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 datapath types, rotate/shift amounts and a rotate helper.
// Common to the sigma unit and the later schedule-expander blocks.
package sha256_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Big sigma 0 (compression, a-path)
    localparam int unsigned S0_R1 = 2;
    localparam int unsigned S0_R2 = 13;
    localparam int unsigned S0_R3 = 22;

    // Big sigma 1 (compression, e-path)
    localparam int unsigned S1_R1 = 6;
    localparam int unsigned S1_R2 = 11;
    localparam int unsigned S1_R3 = 25;

    // Small sigma 0 (message schedule)
    localparam int unsigned s0_R1 = 7;
    localparam int unsigned s0_R2 = 18;
    localparam int unsigned s0_SH = 3;

    // Small sigma 1, reserved for the Function4 datapath
    localparam int unsigned s1_R1 = 17;
    localparam int unsigned s1_R2 = 19;
    localparam int unsigned s1_SH = 10;

    function automatic word_t rotr(input word_t v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma_core.sv
// Combinational sigma kernel: ROTR R1 ^ ROTR R2 ^ (ROTR or SHR) R3.
// Amounts are elaboration constants, so every term is pure wiring.
import sha256_pkg::*;

module sha256_sigma_core #(
    parameter int unsigned R1            = S0_R1,
    parameter int unsigned R2            = S0_R2,
    parameter int unsigned R3            = S0_R3,
    parameter bit          LAST_IS_SHIFT = 1'b0
) (
    input  word_t x,
    output word_t y
);

    word_t rot1;
    word_t rot2;
    word_t last;

    if (R1 == 0 || R1 >= WORD_W || R2 == 0 || R2 >= WORD_W ||
        R3 == 0 || R3 >= WORD_W) begin : g_bad_amount
        $error("sha256_sigma_core: rotate/shift amounts must be 1..31");
    end

    assign rot1 = rotr(x, R1);
    assign rot2 = rotr(x, R2);

    // The schedule sigmas replace the third rotate with a zero-filling shift.
    if (LAST_IS_SHIFT) begin : g_shift
        assign last = x >> R3;
    end else begin : g_rot
        assign last = rotr(x, R3);
    end

    assign y = rot1 ^ rot2 ^ last;

endmodule

// File: rtl/sha256_sigma_unit.sv
// Registered SHA-256 sigma unit: Sigma0, Sigma1 and sigma0 of one word,
// all three available one clock after in_valid, one word per clock.
import sha256_pkg::*;

module sha256_sigma_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic [WIDTH-1:0] f1_out,
    output logic [WIDTH-1:0] f2_out,
    output logic [WIDTH-1:0] f3_out
);

    if (WIDTH != 32) begin : g_bad_width
        $error("sha256_sigma_unit: only WIDTH=32 is supported");
    end

    word_t big_sigma0;
    word_t big_sigma1;
    word_t small_sigma0;

    sha256_sigma_core #(
        .R1(S0_R1), .R2(S0_R2), .R3(S0_R3), .LAST_IS_SHIFT(1'b0)
    ) u_big_sigma0 (
        .x(x),
        .y(big_sigma0)
    );

    sha256_sigma_core #(
        .R1(S1_R1), .R2(S1_R2), .R3(S1_R3), .LAST_IS_SHIFT(1'b0)
    ) u_big_sigma1 (
        .x(x),
        .y(big_sigma1)
    );

    sha256_sigma_core #(
        .R1(s0_R1), .R2(s0_R2), .R3(s0_SH), .LAST_IS_SHIFT(1'b1)
    ) u_small_sigma0 (
        .x(x),
        .y(small_sigma0)
    );

    // Result registers load only on valid words, so an undriven x while idle
    // never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            f1_out    <= '0;
            f2_out    <= '0;
            f3_out    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f1_out <= big_sigma0;
                f2_out <= big_sigma1;
                f3_out <= small_sigma0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_sigma_unit.sv
// Self-checking bench for sha256_sigma_unit: directed vectors, async reset,
// hold behaviour, then a randomized run against a bit-level reference model.
module tb_sha256_sigma_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] x;
    logic        out_valid;
    logic [31:0] f1_out;
    logic [31:0] f2_out;
    logic [31:0] f3_out;

    int n_checks = 0;
    int n_pass   = 0;

    sha256_sigma_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .f1_out    (f1_out),
        .f2_out    (f2_out),
        .f3_out    (f3_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bit i of ROTR n is bit (i+n) mod 32; SHR zero-fills.
    function automatic logic [31:0] m_rotr(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[(i + n) % 32];
        return r;
    endfunction

    function automatic logic [31:0] m_shr(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? v[i + n] : 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] m_f1(input logic [31:0] v);
        return m_rotr(v, 2) ^ m_rotr(v, 13) ^ m_rotr(v, 22);
    endfunction

    function automatic logic [31:0] m_f2(input logic [31:0] v);
        return m_rotr(v, 6) ^ m_rotr(v, 11) ^ m_rotr(v, 25);
    endfunction

    function automatic logic [31:0] m_f3(input logic [31:0] v);
        return m_rotr(v, 7) ^ m_rotr(v, 18) ^ m_shr(v, 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic ev);
        chk({tag, ".f1"}, f1_out, e1);
        chk({tag, ".f2"}, f2_out, e2);
        chk({tag, ".f3"}, f3_out, e3);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    endtask

    logic [31:0] e1, e2, e3;
    logic        ev;
    logic [31:0] xv;
    logic        iv;
    logic        hold_rst;
    int          r;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        x        = '0;

        #3;
        chk_all("reset_initial", 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset wins over in_valid on an edge.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h0000_3FFF;
        @(negedge clk);
        chk_all("reset_beats_valid", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // First capture after reset release.
        @(negedge clk);
        chk_all("vec_3fff", 32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780, 1'b1);
        x = 32'h0000_0001;
        @(negedge clk);
        chk_all("vec_0001", 32'h40080400, 32'h04200080, 32'h02004000, 1'b1);
        x = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_all("vec_ffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF, 1'b1);
        x = 32'h0000_0000;
        @(negedge clk);
        chk_all("vec_zero", 32'h0, 32'h0, 32'h0, 1'b1);

        // Back-to-back stream, then idle with x undriven.
        x = 32'h0000_3FFF;
        @(negedge clk);
        chk_all("b2b_0", 32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780, 1'b1);
        x = 32'h0000_0001;
        @(negedge clk);
        chk_all("b2b_1", 32'h40080400, 32'h04200080, 32'h02004000, 1'b1);
        x = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_all("b2b_2", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF, 1'b1);
        in_valid = 1'b0;
        x        = 'x;
        @(negedge clk);
        chk_all("hold_1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF, 1'b0);
        @(negedge clk);
        chk_all("hold_2", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF, 1'b0);

        // Asynchronous reset mid-cycle, checked before the next clock edge.
        x        = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        e1 = '0; e2 = '0; e3 = '0; ev = 1'b0;
        hold_rst = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            chk_all("rand", e1, e2, e3, ev);
            if (hold_rst) begin
                rst      = 1'b0;
                hold_rst = 1'b0;
            end

            xv = $urandom;
            iv = ($urandom_range(0, 3) != 0);
            in_valid = iv;
            x = (!iv && $urandom_range(0, 1) == 1) ? 'x : xv;

            r = $urandom_range(0, 39);
            if (r == 0) begin
                // Pulse reset between edges: outputs clear at once.
                #1 rst = 1'b1;
                #1;
                chk_all("rand_async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
                e1 = '0; e2 = '0; e3 = '0; ev = 1'b0;
                #1 rst = 1'b0;
            end else if (r == 1) begin
                // Reset held across the edge: it must beat in_valid.
                rst      = 1'b1;
                hold_rst = 1'b1;
            end

            if (hold_rst) begin
                e1 = '0; e2 = '0; e3 = '0; ev = 1'b0;
            end else if (iv) begin
                e1 = m_f1(xv); e2 = m_f2(xv); e3 = m_f3(xv); ev = 1'b1;
            end else begin
                ev = 1'b0;
            end
        end
        @(negedge clk);
        chk_all("rand_final", e1, e2, e3, ev);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
